fft_sym_ctrl: RTL and testbench
===============================

// Module: fft_sym_ctrl
// PURPOSE
//  Symbol sequencer in front of the 128-point FFT + bit-reverse reorder path.
//  Gates an upstream sample stream into contiguous N-sample bursts (fft_en),
//  then blocks further input until the reorder stage has emitted all N outputs.
//  The reorder buffer is single-buffered and must not be written during readout.
//  Counts SYMS symbols per slot and flags underrun and drain timeout.
// PARAMETERS
//  WIDTH    18    sample width, re and im each, signed
//  N        128   FFT size / samples per symbol
//  LOG2N    7     log2(N)
//  SYMS     14    symbols per slot
//  TMO      1024  max cycles in DRAIN without a ro_en pulse
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous reset, active-high
//  start        in   1      1-cycle pulse: begin slot (ignored unless IDLE)
//  abort        in   1      synchronous abort to IDLE, any state
//  in_valid     in   1      upstream sample valid
//  in_ready     out  1      ctrl accepts sample (comb: state==LOAD)
//  in_re,in_im  in   WIDTH  upstream sample, signed
//  fft_en       out  1      registered sample strobe to FFT
//  fft_re,im    out  WIDTH  registered sample to FFT, 0 when fft_en=0
//  ro_en        in   1      reorder output valid (do_en of reorder stage)
//  busy         out  1      state!=IDLE
//  sym_idx      out  4      current symbol index 0..SYMS-1
//  sym_done     out  1      1-cycle pulse: symbol drained, not last
//  slot_done    out  1      1-cycle pulse: last symbol drained
//  err_underrun out  1      sticky: in_valid gap inside a burst
//  err_timeout  out  1      sticky: DRAIN exceeded TMO
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, all counters 0. Asserting rst mid-burst
//   discards the burst. Downstream is reset by the same rst.
//  States: IDLE, LOAD, DRAIN.
//  IDLE:
//   - in_ready=0.
//   - start -> LOAD. Clears sym_idx, ld_cnt, both err flags.
//  LOAD:
//   - in_ready=1.
//   - Accept (in_valid & in_ready): next edge fft_en=1, fft_re/im=in_re/im,
//     ld_cnt++. Accept-to-fft_en latency is 1 cycle.
//   - No accept: fft_en=0, fft_re/im=0.
//   - Accept with ld_cnt==N-1 -> DRAIN. in_ready is 0 on the next cycle.
//   - Gap (in_valid=0) with ld_cnt!=0: set err_underrun, go to DRAIN.
//     The partial symbol still drains; downstream emits N outputs regardless.
//   - Gaps before the first sample (ld_cnt==0) are legal waits.
//  DRAIN:
//   - in_ready=0, fft_en=0.
//   - Count ro_en cycles in ro_cnt.
//   - tmo_cnt clears on each ro_en and increments otherwise.
//     tmo_cnt==TMO-1 -> err_timeout=1, go to IDLE.
//   - ro_cnt reaches N (N-th ro_en cycle):
//     - sym_idx==SYMS-1: slot_done pulse, go to IDLE.
//     - otherwise: sym_done pulse, sym_idx++, ld_cnt=0, ro_cnt=0, go to LOAD.
//     LOAD is re-entered on the cycle after the last ro_en, which guarantees
//     no write overlaps the readout.
//  abort: next edge IDLE, fft_en=0, counters cleared, err flags held.
//   Abort beats start, completion and timeout on the same cycle.
//  start while busy: ignored. ro_en in IDLE or LOAD: ignored, not counted.
//  Counters: ld_cnt and ro_cnt are LOG2N+1 bits, tmo_cnt is clog2(TMO) bits.
//   None wraps; each compare is exact.
// TESTING
//  1 Reset mid-LOAD (rst high after 40 samples) -> all outputs 0,
//    busy=0 immediately, async.
//  2 start, 128 contiguous samples (re=i, im=-i), model ro_en burst of 128
//    after 300 cycles -> fft_en high exactly 128 cycles, fft_re=i one cycle
//    after accept, sym_done once, sym_idx=1, in_ready low during DRAIN.
//  3 Full slot of 14 symbols with random pre-burst waits -> 13 sym_done,
//    1 slot_done, final state IDLE, 1792 fft_en cycles total.
//  4 Drop in_valid after sample 60 -> err_underrun=1, DRAIN entered,
//    slot continues. Next start clears err_underrun.
//  5 No ro_en during DRAIN -> err_timeout=1 at exactly TMO cycles, IDLE.
//  6 abort together with the 128th ro_en -> IDLE, no sym_done or slot_done.
//    start while busy -> no effect.

Source files
------------

// File: rtl/fft_sym_ctrl.sv
// Symbol sequencer ahead of the 128-point FFT and bit-reverse reorder stage.
// Gates samples into N-sample bursts and holds input off until readout ends.
module fft_sym_ctrl #(
    parameter int WIDTH = 18,
    parameter int N     = 128,
    parameter int LOG2N = 7,
    parameter int SYMS  = 14,
    parameter int TMO   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             fft_en,
    output logic [WIDTH-1:0] fft_re,
    output logic [WIDTH-1:0] fft_im,
    input  logic             ro_en,
    output logic             busy,
    output logic [3:0]       sym_idx,
    output logic             sym_done,
    output logic             slot_done,
    output logic             err_underrun,
    output logic             err_timeout
);

    localparam int CW = LOG2N + 1;
    localparam int TW = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ld_cnt_q;
    logic [CW-1:0]   ro_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [3:0]      sym_idx_q;
    logic            fft_en_q;
    logic [WIDTH-1:0] fft_re_q;
    logic [WIDTH-1:0] fft_im_q;
    logic            sym_done_q;
    logic            slot_done_q;
    logic            err_und_q;
    logic            err_tmo_q;

    logic [CW-1:0]   ro_cnt_d;
    assign ro_cnt_d = ro_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            ro_cnt_q    <= '0;
            tmo_cnt_q   <= '0;
            sym_idx_q   <= '0;
            fft_en_q    <= 1'b0;
            fft_re_q    <= '0;
            fft_im_q    <= '0;
            sym_done_q  <= 1'b0;
            slot_done_q <= 1'b0;
            err_und_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            fft_en_q    <= 1'b0;
            fft_re_q    <= '0;
            fft_im_q    <= '0;
            sym_done_q  <= 1'b0;
            slot_done_q <= 1'b0;
            if (abort) begin
                // error flags survive an abort so software can still read them
                state_q   <= IDLE;
                ld_cnt_q  <= '0;
                ro_cnt_q  <= '0;
                tmo_cnt_q <= '0;
                sym_idx_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= LOAD;
                            ld_cnt_q  <= '0;
                            ro_cnt_q  <= '0;
                            tmo_cnt_q <= '0;
                            sym_idx_q <= '0;
                            err_und_q <= 1'b0;
                            err_tmo_q <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (in_valid) begin
                            fft_en_q <= 1'b1;
                            fft_re_q <= in_re;
                            fft_im_q <= in_im;
                            ld_cnt_q <= ld_cnt_q + 1'b1;
                            if (ld_cnt_q == CW'(N - 1)) begin
                                state_q   <= DRAIN;
                                ro_cnt_q  <= '0;
                                tmo_cnt_q <= '0;
                            end
                        end else if (ld_cnt_q != '0) begin
                            // partial symbol still drains a full N outputs
                            err_und_q <= 1'b1;
                            state_q   <= DRAIN;
                            ro_cnt_q  <= '0;
                            tmo_cnt_q <= '0;
                        end
                    end
                    DRAIN: begin
                        if (ro_en) begin
                            tmo_cnt_q <= '0;
                            ro_cnt_q  <= ro_cnt_d;
                            if (ro_cnt_d == CW'(N)) begin
                                if (sym_idx_q == 4'(SYMS - 1)) begin
                                    slot_done_q <= 1'b1;
                                    state_q     <= IDLE;
                                end else begin
                                    sym_done_q <= 1'b1;
                                    sym_idx_q  <= sym_idx_q + 1'b1;
                                    ld_cnt_q   <= '0;
                                    ro_cnt_q   <= '0;
                                    state_q    <= LOAD;
                                end
                            end
                        end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                            err_tmo_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign fft_en       = fft_en_q;
    assign fft_re       = fft_re_q;
    assign fft_im       = fft_im_q;
    assign sym_idx      = sym_idx_q;
    assign sym_done     = sym_done_q;
    assign slot_done    = slot_done_q;
    assign err_underrun = err_und_q;
    assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_fft_sym_ctrl.sv
// Self-checking bench for fft_sym_ctrl: scoreboard on the FFT sample
// stream, a per-symbol vector table for a full slot, and corner sequences.
module tb_fft_sym_ctrl;
    localparam int W    = 18;
    localparam int N    = 128;
    localparam int SYMS = 14;
    localparam int TMO  = 1024;

    logic         clk = 1'b0;
    logic         rst, start, abort, in_valid, ro_en;
    logic [W-1:0] in_re, in_im;
    logic         in_ready, fft_en, busy;
    logic [W-1:0] fft_re, fft_im;
    logic [3:0]   sym_idx;
    logic         sym_done, slot_done, err_underrun, err_timeout;

    fft_sym_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .fft_en(fft_en), .fft_re(fft_re), .fft_im(fft_im),
        .ro_en(ro_en), .busy(busy), .sym_idx(sym_idx),
        .sym_done(sym_done), .slot_done(slot_done),
        .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fft   = 0;
    int n_symd  = 0;
    int n_slotd = 0;
    logic [2*W-1:0] sbq[$];

    typedef struct {
        int         pre;
        int         gap;
        logic [3:0] e_idx;
        int         e_symd;
        int         e_slotd;
        logic       e_busy;
    } vec_t;
    vec_t tbl[SYMS];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // advance one cycle and check everything the DUT emitted at that edge
    task automatic tick();
        logic [2*W-1:0] e;
        @(negedge clk);
        if (fft_en) begin
            n_fft++;
            if (sbq.size() == 0) begin
                chk("fft_en_spurious", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("fft_data", {fft_re, fft_im}, e);
            end
        end else begin
            chk("fft_data_idle", {fft_re, fft_im}, 0);
        end
        chk("sb_latency", sbq.size(), 0);
        if (sym_done) n_symd++;
        if (slot_done) n_slotd++;
    endtask

    task automatic load_sym(input int ns, input int pre, input int base);
        in_valid = 1'b0;
        repeat (pre) tick();
        for (int i = 0; i < ns; i++) begin
            in_valid = 1'b1;
            in_re = W'(base + i);
            in_im = W'(-(base + i));
            if (in_ready) sbq.push_back({in_re, in_im});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic ro_burst(input int n);
        ro_en = 1'b1;
        repeat (n) tick();
        ro_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, s0, s1, bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; ro_en = 1'b0;
        in_re = '0; in_im = '0;

        for (int i = 0; i < SYMS; i++) begin
            tbl[i].pre     = int'($urandom_range(0, 20));
            tbl[i].gap     = 5 + i;
            tbl[i].e_idx   = 4'(i + 1);
            tbl[i].e_symd  = 1;
            tbl[i].e_slotd = 0;
            tbl[i].e_busy  = 1'b1;
        end
        tbl[SYMS-1].e_idx   = 4'd13;
        tbl[SYMS-1].e_symd  = 0;
        tbl[SYMS-1].e_slotd = 1;
        tbl[SYMS-1].e_busy  = 1'b0;

        tick();
        chk("reset_outs", {busy, in_ready, fft_en, sym_idx, sym_done,
            slot_done, err_underrun, err_timeout}, 0);
        rst = 1'b0;
        tick();

        // 1: asynchronous reset in the middle of a burst
        pulse_start();
        load_sym(40, 3, 1000);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_outs", {in_ready, fft_en, fft_re, fft_im,
            sym_idx}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 2: one symbol, late readout
        pulse_start();
        f0 = n_fft;
        s0 = n_symd;
        load_sym(N, 0, 0);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_busy", busy, 1);
        bad = 0;
        repeat (300) begin
            tick();
            if (in_ready || fft_en) bad++;
        end
        chk("drain_quiet", bad, 0);
        ro_burst(N);
        chk("sym1_fft_cnt", n_fft - f0, N);
        chk("sym1_done_cnt", n_symd - s0, 1);
        chk("sym1_idx", sym_idx, 1);
        chk("sym1_reload", in_ready, 1);

        // 3: full slot from the vector table
        do_abort();
        chk("abort_idle", busy, 0);
        chk("abort_idx", sym_idx, 0);
        pulse_start();
        f0 = n_fft;
        s0 = n_symd;
        s1 = n_slotd;
        for (int i = 0; i < SYMS; i++) begin
            int a, b;
            a = n_symd;
            b = n_slotd;
            load_sym(N, tbl[i].pre, i * N);
            repeat (tbl[i].gap) tick();
            ro_burst(N);
            chk("tbl_idx", sym_idx, tbl[i].e_idx);
            chk("tbl_symd", n_symd - a, tbl[i].e_symd);
            chk("tbl_slotd", n_slotd - b, tbl[i].e_slotd);
            chk("tbl_busy", busy, tbl[i].e_busy);
        end
        chk("slot_fft_cnt", n_fft - f0, SYMS * N);
        chk("slot_symd", n_symd - s0, SYMS - 1);
        chk("slot_slotd", n_slotd - s1, 1);

        // 4: underrun after sample 60
        pulse_start();
        chk("und_clear0", err_underrun, 0);
        f0 = n_fft;
        load_sym(60, 2, 5000);
        tick();
        chk("und_flag", err_underrun, 1);
        chk("und_drain", {busy, in_ready}, 2'b10);
        chk("und_fft_cnt", n_fft - f0, 60);
        ro_burst(N);
        chk("und_continue_idx", sym_idx, 1);
        chk("und_continue_rdy", in_ready, 1);
        do_abort();
        chk("und_held", err_underrun, 1);
        pulse_start();
        chk("und_cleared", err_underrun, 0);
        chk("und_restart", in_ready, 1);

        // 5: drain timeout
        load_sym(N, 0, 7000);
        repeat (TMO - 1) tick();
        chk("tmo_early", {err_timeout, busy}, 2'b01);
        tick();
        chk("tmo_flag", err_timeout, 1);
        chk("tmo_idle", busy, 0);

        // 6: ro_en in LOAD ignored, start while busy, abort beats completion
        pulse_start();
        chk("tmo_cleared", err_timeout, 0);
        ro_burst(10);
        load_sym(N - 1, 0, 9000);
        chk("pre_last_rdy", in_ready, 1);
        in_valid = 1'b1;
        start = 1'b1;
        in_re = W'(9127);
        in_im = W'(-9127);
        if (in_ready) sbq.push_back({in_re, in_im});
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("busy_start_ld", in_ready, 0);
        chk("busy_start_und", err_underrun, 0);
        pulse_start();
        chk("busy_start_drain", {busy, in_ready}, 2'b10);
        s0 = n_symd;
        s1 = n_slotd;
        ro_burst(N - 1);
        chk("ro_load_ignored", n_symd - s0, 0);
        chk("ro_partial_busy", busy, 1);
        ro_en = 1'b1;
        abort = 1'b1;
        tick();
        ro_en = 1'b0;
        abort = 1'b0;
        chk("abort_win_busy", busy, 0);
        chk("abort_win_symd", n_symd - s0, 0);
        chk("abort_win_slotd", n_slotd - s1, 0);
        chk("abort_win_idx", sym_idx, 0);
        tick();
        chk("abort_win_late", {sym_done, slot_done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
